// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, cause codes,
// access op encodings and mstatus field positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [4:0] CAUSE_MTI  = 5'd7;
  localparam logic [4:0] CAUSE_MEI  = 5'd11;
  localparam int         LOCAL_BASE = 16;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op)
      OP_SET:   return old | wd;
      OP_CLEAR: return old & ~wd;
      default:  return wd;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// CNT_W-bit free-running counter exposed as two 32-bit halves; a half-word
// write replaces that half and suppresses the increment for that cycle.
module csr_counter #(
  parameter int CNT_W = 64
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (wr_lo) cnt[31:0] <= wdata;
    else if (wr_hi) cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign value = 64'(cnt);

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: mstatus MIE/MPIE stacking, trap/mret sequencing,
// fixed-priority interrupt cause encoding, vectored mtvec and 64-bit counters.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_req,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               timer_irq,
  input  logic               ext_irq,
  input  logic [NUM_IRQ-1:0] local_irq,
  output logic               irq_pending,
  input  logic               trap_enter,
  input  logic               trap_is_irq,
  input  logic [4:0]         trap_code,
  input  logic [31:0]        trap_pc,
  input  logic               mret,
  input  logic               instr_retire,
  output logic [31:0]        trap_vector,
  output logic [31:0]        mepc_o
);

  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << LOCAL_BASE;
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | (32'h1 << CAUSE_MTI) | (32'h1 << CAUSE_MEI);

  csr_op_e     op_e;
  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] mstatus_v, mip_v, pend, rd_val, wval, tv_base;
  logic [63:0] cyc, ret;
  logic        legal, illegal, wr_en, irq_sel;
  logic [4:0]  irq_cause;

  assign op_e = csr_op_e'(csr_op);

  always_comb begin
    mstatus_v = '0;
    mstatus_v[MSTATUS_MIE]  = st_mie;
    mstatus_v[MSTATUS_MPIE] = st_mpie;
    mip_v = '0;
    mip_v[CAUSE_MTI] = timer_irq;
    mip_v[CAUSE_MEI] = ext_irq;
    mip_v[LOCAL_BASE +: NUM_IRQ] = local_irq;
  end

  assign pend        = mip_v & mie_q;
  assign irq_pending = st_mie & (|pend);

  // Descending scan so the lowest-index local line wins; MTI then MEI override.
  always_comb begin
    irq_sel   = 1'b0;
    irq_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[LOCAL_BASE + i]) begin
        irq_sel   = 1'b1;
        irq_cause = 5'(LOCAL_BASE + i);
      end
    end
    if (pend[CAUSE_MTI]) begin irq_sel = 1'b1; irq_cause = CAUSE_MTI; end
    if (pend[CAUSE_MEI]) begin irq_sel = 1'b1; irq_cause = CAUSE_MEI; end
  end

  always_comb begin
    legal  = 1'b1;
    rd_val = '0;
    case (csr_addr)
      CSR_MSTATUS:   rd_val = mstatus_v;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MIP:       rd_val = mip_v;
      CSR_MCYCLE:    rd_val = cyc[31:0];
      CSR_MINSTRET:  rd_val = ret[31:0];
      CSR_MCYCLEH:   rd_val = cyc[63:32];
      CSR_MINSTRETH: rd_val = ret[63:32];
      default:       legal  = 1'b0;
    endcase
  end

  assign illegal = !legal || (csr_addr == CSR_MIP && op_e != OP_READ);
  assign wr_en   = csr_req && op_e != OP_READ && !illegal;
  assign wval    = csr_apply(op_e, rd_val, csr_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (trap_enter) begin
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        mepc_q   <= trap_pc & ~32'h3;
        mcause_q <= {trap_is_irq, 26'b0, trap_is_irq ? irq_cause : trap_code};
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en && csr_addr == CSR_MSTATUS) begin
        st_mie  <= wval[MSTATUS_MIE];
        st_mpie <= wval[MSTATUS_MPIE];
      end
      // mret leaves mepc/mcause alone, so only a trap blocks these writes.
      if (!trap_enter && wr_en && csr_addr == CSR_MEPC)   mepc_q   <= wval & ~32'h3;
      if (!trap_enter && wr_en && csr_addr == CSR_MCAUSE) mcause_q <= wval;
      if (wr_en && csr_addr == CSR_MIE)      mie_q      <= wval & MIE_MASK;
      if (wr_en && csr_addr == CSR_MTVEC)    mtvec_q    <= {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
      if (wr_en && csr_addr == CSR_MSCRATCH) mscratch_q <= wval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
    end else begin
      csr_illegal <= csr_req && illegal;
      if (csr_req) csr_rdata <= illegal ? '0 : rd_val;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
    .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
    .wdata (wval),
    .value (cyc)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire),
    .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
    .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
    .wdata (wval),
    .value (ret)
  );

  assign tv_base     = {mtvec_q[31:2], 2'b00};
  assign trap_vector = (mtvec_q[1:0] == 2'b01 && irq_sel) ? tv_base + {25'b0, irq_cause, 2'b00}
                                                          : tv_base;
  assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: register-level model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_csr_file_m;

  localparam int          NI   = 4;
  localparam int          CW   = 48;
  localparam logic [31:0] MRST = 32'h0000_0100;
  localparam logic [63:0] CMASK = (64'h1 << CW) - 64'h1;
  localparam logic [31:0] MIE_W = 32'h0000_0880 | (((32'h1 << NI) - 32'h1) << 16);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csr_req = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [1:0]    csr_op = '0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_rdata;
  logic          csr_illegal;
  logic          timer_irq = 1'b0, ext_irq = 1'b0;
  logic [NI-1:0] local_irq = '0;
  logic          irq_pending;
  logic          trap_enter = 1'b0, trap_is_irq = 1'b0, mret = 1'b0, instr_retire = 1'b0;
  logic [4:0]    trap_code = '0;
  logic [31:0]   trap_pc = '0;
  logic [31:0]   trap_vector, mepc_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_file_m #(.NUM_IRQ(NI), .CNT_W(CW), .MTVEC_RST(MRST)) dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .timer_irq(timer_irq), .ext_irq(ext_irq), .local_irq(local_irq), .irq_pending(irq_pending),
    .trap_enter(trap_enter), .trap_is_irq(trap_is_irq), .trap_code(trap_code), .trap_pc(trap_pc),
    .mret(mret), .instr_retire(instr_retire), .trap_vector(trap_vector), .mepc_o(mepc_o)
  );

  // Architectural state of the model
  logic        mb_mie, mb_mpie, e_ill;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, e_rdata;
  logic [63:0] m_cyc, m_ret;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] mip_now();
    return (32'(timer_irq) << 7) | (32'(ext_irq) << 11) | (32'(local_irq) << 16);
  endfunction

  function automatic int enc(input logic [31:0] p);
    if (p[11]) return 11;
    if (p[7])  return 7;
    for (int i = 0; i < NI; i++) if (p[16+i]) return 16 + i;
    return -1;
  endfunction

  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 24'b0, mb_mpie, 3'b0, mb_mie, 3'b0};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, mip_now()};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB02: return {1'b1, m_ret[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB82: return {1'b1, m_ret[63:32]};
      default: return 33'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_tv();
    int c;
    c = enc(mip_now() & m_mie);
    if (m_mtvec[1:0] == 2'b01 && c >= 0) return (m_mtvec & ~32'h3) + 32'(4 * c);
    return m_mtvec & ~32'h3;
  endfunction

  // Model update at each clock edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mb_mie = 0; mb_mpie = 0; m_mie = 0; m_mtvec = MRST; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0; e_rdata = 0; e_ill = 0;
    end else begin : upd
      logic [32:0] r;
      logic        ill, wr, nmie, nmpie;
      logic [31:0] nv;
      logic [63:0] nc, nr;
      int          c;
      r   = mread(csr_addr);
      ill = !r[32] || (csr_addr == 12'h344 && csr_op != 2'b00);
      wr  = csr_req && csr_op != 2'b00 && !ill;
      case (csr_op)
        2'b10:   nv = r[31:0] | csr_wdata;
        2'b11:   nv = r[31:0] & ~csr_wdata;
        default: nv = csr_wdata;
      endcase
      nmie = mb_mie; nmpie = mb_mpie;
      nc = (m_cyc + 64'h1) & CMASK;
      nr = instr_retire ? (m_ret + 64'h1) & CMASK : m_ret;
      c  = enc(mip_now() & m_mie);
      if (wr) begin
        case (csr_addr)
          12'h300: begin nmie = nv[3]; nmpie = nv[7]; end
          12'h304: m_mie = nv & MIE_W;
          12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: nc = {m_cyc[63:32], nv} & CMASK;
          12'hB80: nc = {nv, m_cyc[31:0]} & CMASK;
          12'hB02: nr = {m_ret[63:32], nv} & CMASK;
          12'hB82: nr = {nv, m_ret[31:0]} & CMASK;
          default: ;
        endcase
      end
      if (trap_enter) begin
        nmpie = mb_mie; nmie = 0;
        m_mepc = trap_pc & ~32'h3;
        m_mcause = trap_is_irq ? (32'h8000_0000 | 32'(c < 0 ? 0 : c)) : {27'b0, trap_code};
      end else if (mret) begin
        nmie = mb_mpie; nmpie = 1;
      end
      mb_mie = nmie; mb_mpie = nmpie; m_cyc = nc; m_ret = nr;
      if (csr_req) begin
        e_rdata = ill ? 32'h0 : r[31:0];
        e_ill   = ill;
      end else e_ill = 0;
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    cmp("rdata", csr_rdata, e_rdata);
    cmp("illegal", 32'(csr_illegal), 32'(e_ill));
    cmp("irq_pending", 32'(irq_pending), 32'(mb_mie & (|(mip_now() & m_mie))));
    cmp("trap_vector", trap_vector, exp_tv());
    cmp("mepc_o", mepc_o, m_mepc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_req = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
    step();
    csr_req = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  initial begin
    repeat (3) step();
    cmp("lit_reset_rdata", csr_rdata, 32'h0);
    cmp("lit_reset_ill", 32'(csr_illegal), 32'h0);
    cmp("lit_reset_tv", trap_vector, 32'h100);
    rst_n = 1'b1;
    step();

    acc(12'h305, 2'b00, 0);        cmp("lit_mtvec_rst", csr_rdata, 32'h100);
    cmp("lit_mtvec_ill", 32'(csr_illegal), 32'h0);
    acc(12'h7C0, 2'b00, 0);        cmp("lit_bad_rdata", csr_rdata, 32'h0);
    cmp("lit_bad_ill", 32'(csr_illegal), 32'h1);
    step();                        cmp("lit_ill_clear", 32'(csr_illegal), 32'h0);

    acc(12'h304, 2'b10, 32'h880);
    acc(12'h300, 2'b10, 32'h8);
    timer_irq = 1; ext_irq = 1; #1;
    cmp("lit_pending", 32'(irq_pending), 32'h1);
    trap_enter = 1; trap_is_irq = 1; trap_pc = 32'h2004;
    step();
    trap_enter = 0; trap_is_irq = 0;
    cmp("lit_mepc", mepc_o, 32'h2004);
    acc(12'h342, 2'b00, 0);        cmp("lit_mcause_irq", csr_rdata, 32'h8000_000B);
    acc(12'h300, 2'b00, 0);        cmp("lit_mstatus_trap", csr_rdata, 32'h80);
    cmp("lit_pending_off", 32'(irq_pending), 32'h0);

    timer_irq = 0; ext_irq = 0;
    acc(12'h305, 2'b01, 32'h1001);
    acc(12'h304, 2'b01, 32'h1 << 18);
    local_irq = 4'b0100; #1;       cmp("lit_tv_vec18", trap_vector, 32'h1048);
    local_irq = 4'b0110;
    acc(12'h304, 2'b10, 32'h1 << 17);
    cmp("lit_tv_vec17", trap_vector, 32'h1044);
    acc(12'h305, 2'b01, 32'h1000); cmp("lit_tv_direct", trap_vector, 32'h1000);
    acc(12'h305, 2'b01, 32'h1003);
    acc(12'h305, 2'b00, 0);        cmp("lit_mtvec_mode", csr_rdata, 32'h1000);

    acc(12'h300, 2'b01, 32'h8);
    csr_req = 1; csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h8;
    trap_enter = 1; trap_code = 5'd2; trap_pc = 32'h3000;
    step();
    csr_req = 0; csr_op = 0; csr_wdata = 0; trap_enter = 0;
    acc(12'h300, 2'b00, 0);        cmp("lit_trap_wins", csr_rdata, 32'h80);
    acc(12'h342, 2'b00, 0);        cmp("lit_mcause_exc", csr_rdata, 32'h2);
    cmp("lit_mepc2", mepc_o, 32'h3000);
    mret = 1; step(); mret = 0;
    acc(12'h300, 2'b00, 0);        cmp("lit_mret", csr_rdata, 32'h88);
    trap_enter = 1; mret = 1; step(); trap_enter = 0; mret = 0;
    acc(12'h300, 2'b00, 0);        cmp("lit_trap_over_mret", csr_rdata, 32'h80);

    acc(12'hB80, 2'b01, 32'h0);
    acc(12'hB00, 2'b01, 32'hFFFF_FFFF);
    step();
    acc(12'hB80, 2'b00, 0);        cmp("lit_mcycle_carry", csr_rdata, 32'h1);
    acc(12'hB00, 2'b01, 32'h5);
    acc(12'hB00, 2'b00, 0);        cmp("lit_mcycle_hold", csr_rdata, 32'h5);
    acc(12'hB00, 2'b00, 0);        cmp("lit_mcycle_inc", csr_rdata, 32'h6);
    acc(12'hB80, 2'b01, 32'hFFFF_FFFF);
    acc(12'hB80, 2'b00, 0);        cmp("lit_mcycleh_width", csr_rdata, 32'h0000_FFFF);
    acc(12'hB02, 2'b01, 32'd10);
    instr_retire = 1; repeat (3) step(); instr_retire = 0;
    acc(12'hB02, 2'b00, 0);        cmp("lit_minstret", csr_rdata, 32'd13);

    acc(12'h344, 2'b10, 32'h80);   cmp("lit_mip_ro", 32'(csr_illegal), 32'h1);
    acc(12'h344, 2'b00, 0);        cmp("lit_mip_live", csr_rdata, 32'h0006_0000);
    acc(12'h300, 2'b10, 32'h0);
    acc(12'h300, 2'b00, 0);        cmp("lit_set_zero", csr_rdata, 32'h80);
    acc(12'h340, 2'b01, 32'hA5A5_0F0F);
    acc(12'h340, 2'b11, 32'h0000_0F0F);
    acc(12'h340, 2'b00, 0);        cmp("lit_mscratch_clr", csr_rdata, 32'hA5A5_0000);

    csr_req = 1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'hDEAD;
    #2 rst_n = 0;
    csr_req = 0; csr_op = 0; csr_wdata = 0;
    step(); step();
    rst_n = 1;
    step();
    acc(12'h340, 2'b00, 0);        cmp("lit_abort_mscratch", csr_rdata, 32'h0);
    acc(12'h305, 2'b00, 0);        cmp("lit_abort_mtvec", csr_rdata, 32'h100);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Machine-mode CSR file; parametrised successor of the core's current five-register CSR block.
- Adds mstatus MIE/MPIE stacking, trap-entry and mret sequencing, and NUM_IRQ local interrupt lines with fixed-priority cause encoding.
- Adds vectored mtvec, mscratch, and 64-bit-visible mcycle/minstret counters.
- Sits beside the decode/execute stage. Core issues CSR accesses and trap/mret strobes; the block returns registered read data and the trap target.

Parameters:
NUM_IRQ, 4, local interrupt lines mapped to mip/mie bits 16..16+NUM_IRQ-1 (1..16)
CNT_W, 64, implemented counter width (33..64); bits above CNT_W read 0
MTVEC_RST, 32'h0000_0000, mtvec reset value

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
csr_req  in  1  CSR access this cycle
csr_addr  in  12  CSR address
csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only
csr_wdata  in  32  write/set/clear operand
csr_rdata  out  32  registered read data
csr_illegal  out  1  registered; unimplemented address, or write to read-only
timer_irq  in  1  level, mip.MTIP (bit 7)
ext_irq  in  1  level, mip.MEIP (bit 11)
local_irq  in  NUM_IRQ  level, mip bits 16+i
irq_pending  out  1  comb: mstatus.MIE & |(mip & mie)
trap_enter  in  1  core takes trap at instruction boundary
trap_is_irq  in  1  trap is interrupt (cause from internal encoder)
trap_code  in  5  exception code when trap_is_irq=0
trap_pc  in  32  pc saved to mepc
mret  in  1  return from trap
instr_retire  in  1  one instruction retired
trap_vector  out  32  comb trap target
mepc_o  out  32  current mepc

Behaviour:
- Address map:
  - mstatus 0x300: only MIE bit3 and MPIE bit7 writable; other bits read 0.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mip 0x344 (read-only).
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
- mie: writable bits are 7, 11 and 16..16+NUM_IRQ-1. All other bits read 0.
- mip: sampled live from the irq inputs. Write/set/clear to mip raises csr_illegal and has no effect.
- Read path: csr_rdata and csr_illegal update one cycle after csr_req. With no csr_req, csr_rdata holds and csr_illegal clears.
- Write ops: write = wdata; set = old|wdata; clear = old&~wdata. Masked to writable bits and applied at the clock edge. Read returns the pre-update value.
- Illegal addresses: read 0, csr_illegal=1, no state change.
- Interrupt cause priority (fixed):
  - MEI (11) > MTI (7) > local irq lowest index first (cause 16+i).
  - Encoder considers only mip&mie bits, independent of mstatus.MIE.
- Trap entry (trap_enter=1):
  - mepc <= trap_pc; mstatus.MPIE <= MIE; MIE <= 0.
  - mcause <= {trap_is_irq, 26'b0, cause5}, where cause5 = encoder output if irq, else trap_code.
- mret: MIE <= MPIE; MPIE <= 1.
- trap_vector:
  - mtvec[1:0]=01 and pending interrupt selected: {mtvec[31:2],2'b0} + 4*cause.
  - Otherwise {mtvec[31:2],2'b0}. mtvec mode values 1x are stored as 00.
- Same-cycle priority, per register:
  - trap_enter > mret > CSR write.
  - trap_enter and mret together: trap_enter wins, mret ignored.
  - A CSR write to a register not touched by the higher-priority event still takes effect.
- Counters:
  - mcycle increments every cycle; minstret increments on instr_retire. Both wrap modulo 2^CNT_W.
  - CSR write to the low/high half replaces that half, and suppresses that counter's increment for that cycle.
  - Reads return the pre-increment value.
- Reset: all registers 0 except mtvec=MTVEC_RST. csr_rdata=0, csr_illegal=0. Reset mid-access aborts the access with no partial update.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants.
  - Cause codes (MTI=7, MEI=11, LOCAL_BASE=16).
  - csr_op encodings.
  - mstatus bit positions.
- Sub-module csr_counter (CNT_W-wide counter with inc enable and lo/hi half-word write ports), instantiated twice.

Test Plan:
- Reset, read 0x305 with MTVEC_RST=0x100 -> next cycle csr_rdata=0x100, csr_illegal=0; read 0x7C0 -> csr_rdata=0, csr_illegal=1.
- Set mie=0x880, mstatus=0x8; assert timer_irq and ext_irq -> irq_pending=1. trap_enter, trap_is_irq=1, trap_pc=0x2004 -> mepc=0x2004, mcause=0x8000000B, mstatus=0x80.
- mtvec=0x1001, local_irq[2] only, mie bit18 set -> trap_vector=0x1048. With mtvec=0x1000 -> 0x1000.
- trap_enter and csr write mstatus=0x8 in the same cycle -> mstatus=0x80 (trap wins). Following mret -> mstatus=0x88.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later the mcycleh read returns 1. Write mcycle=5 -> that cycle no increment, then 6.
- Set op on 0x344 with wdata=0x80 -> csr_illegal=1, mip unchanged; set op with wdata=0 on mstatus -> no change.
